// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg: shared constants for the multi-section perf counter.
// Register offsets, status bit positions and the global-reset bit.
package perf_counter_pkg;

    typedef enum logic [1:0] {
        OFF_TIME_LO = 2'd0,
        OFF_TIME_HI = 2'd1,
        OFF_EVENT   = 2'd2,
        OFF_STATUS  = 2'd3
    } offset_e;

    localparam int ST_ENABLE    = 0;
    localparam int ST_TIME_OVF  = 1;
    localparam int ST_EVENT_OVF = 2;

    localparam int GLOBAL_RESET_BIT = 0;

endpackage

// File: rtl/perf_counter_section.sv
// perf_counter_section: one measurement section.
// Holds enable, time/event counters, high-word snapshot and sticky flags.
module perf_counter_section
    import perf_counter_pkg::*;
#(
    parameter int TIME_W   = 64,
    parameter int EVENT_W  = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stop,
    input  logic               go,
    input  logic               global_enable,
    input  logic               global_reset,
    input  logic               snap,
    input  logic [1:0]         w1c,
    output logic               enable,
    output logic [31:0]        time_lo,
    output logic [EVENT_W-1:0] event_cnt,
    output logic [TIME_W-33:0] snapshot,
    output logic               time_ovf,
    output logic               event_ovf
);

    logic [TIME_W-1:0] time_cnt;
    logic [TIME_W-1:0] time_nxt;
    logic              time_inc;
    logic              event_inc;
    logic              time_max;
    logic              event_max;

    assign time_inc  = enable & global_enable;
    assign event_inc = go & global_enable;
    assign time_max  = &time_cnt;
    assign event_max = &event_cnt;
    assign time_lo   = time_cnt[31:0];

    assign time_nxt = global_reset ? '0
                    : (time_inc && !(SATURATE && time_max)) ? time_cnt + TIME_W'(1)
                    : time_cnt;

    // Time counter takes its precomputed next value every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            time_cnt <= '0;
        end else begin
            time_cnt <= time_nxt;
        end
    end

    // Enable, event counter and snapshot; global reset overrides all
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable    <= 1'b0;
            event_cnt <= '0;
            snapshot  <= '0;
        end else if (global_reset) begin
            enable    <= 1'b0;
            event_cnt <= '0;
            snapshot  <= '0;
        end else begin
            if (go) begin
                enable <= 1'b1;
            end else if (stop) begin
                enable <= 1'b0;
            end
            if (event_inc && !(SATURATE && event_max)) begin
                event_cnt <= event_cnt + EVENT_W'(1);
            end
            if (snap) begin
                snapshot <= time_cnt[TIME_W-1:32];
            end
        end
    end

    // Sticky overflow flags: a new overflow wins over a W1C clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            time_ovf  <= 1'b0;
            event_ovf <= 1'b0;
        end else if (global_reset) begin
            time_ovf  <= 1'b0;
            event_ovf <= 1'b0;
        end else begin
            if (time_inc && time_max) begin
                time_ovf <= 1'b1;
            end else if (w1c[0]) begin
                time_ovf <= 1'b0;
            end
            if (event_inc && event_max) begin
                event_ovf <= 1'b1;
            end else if (w1c[1]) begin
                event_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/perf_counter_multi.sv
// perf_counter_multi: Avalon-MM multi-section performance counter.
// Section 0 gates counting everywhere and owns the global reset.
module perf_counter_multi
    import perf_counter_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int ADDR_W       = 4,
    parameter int TIME_W       = 64,
    parameter int EVENT_W      = 32,
    parameter bit SATURATE     = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              begintransfer,
    input  logic              write,
    input  logic              read,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata
);

    localparam int SEC_W = ADDR_W - 2;

    logic [SEC_W-1:0]        sec;
    offset_e                 off;
    logic                    wr_stb;
    logic                    rd_stb;
    logic                    global_reset;
    logic                    global_enable;
    logic                    unused_wdata;
    logic [31:0]             rd_mux;

    logic [NUM_SECTIONS-1:0] hit;
    logic [NUM_SECTIONS-1:0] stop;
    logic [NUM_SECTIONS-1:0] go;
    logic [NUM_SECTIONS-1:0] snap;
    logic [NUM_SECTIONS-1:0] enable;
    logic [NUM_SECTIONS-1:0] time_ovf;
    logic [NUM_SECTIONS-1:0] event_ovf;
    logic [31:0]             time_lo   [NUM_SECTIONS];
    logic [EVENT_W-1:0]      event_cnt [NUM_SECTIONS];
    logic [TIME_W-33:0]      snapshot  [NUM_SECTIONS];

    assign sec    = address[ADDR_W-1:2];
    assign off    = offset_e'(address[1:0]);
    assign wr_stb = write & begintransfer;
    assign rd_stb = read & begintransfer;

    assign global_reset  = stop[0] & writedata[GLOBAL_RESET_BIT];
    assign global_enable = enable[0] | go[0];
    assign unused_wdata  = ^writedata[31:3];

    for (genvar s = 0; s < NUM_SECTIONS; s++) begin : gen_sec
        logic       wr_status;
        logic [1:0] w1c;

        assign hit[s]    = (sec == SEC_W'(s));
        assign stop[s]   = wr_stb & hit[s] & (off == OFF_TIME_LO);
        assign go[s]     = wr_stb & hit[s] & (off == OFF_TIME_HI);
        assign snap[s]   = rd_stb & hit[s] & (off == OFF_TIME_LO);
        assign wr_status = wr_stb & hit[s] & (off == OFF_STATUS);
        assign w1c       = {2{wr_status}}
                         & writedata[ST_EVENT_OVF:ST_TIME_OVF];

        perf_counter_section #(
            .TIME_W   (TIME_W),
            .EVENT_W  (EVENT_W),
            .SATURATE (SATURATE)
        ) u_sec (
            .clk           (clk),
            .reset_n       (reset_n),
            .stop          (stop[s]),
            .go            (go[s]),
            .global_enable (global_enable),
            .global_reset  (global_reset),
            .snap          (snap[s]),
            .w1c           (w1c),
            .enable        (enable[s]),
            .time_lo       (time_lo[s]),
            .event_cnt     (event_cnt[s]),
            .snapshot      (snapshot[s]),
            .time_ovf      (time_ovf[s]),
            .event_ovf     (event_ovf[s])
        );
    end

    // Read mux; unimplemented sections fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (sec == SEC_W'(s)) begin
                unique case (off)
                    OFF_TIME_LO: rd_mux = time_lo[s];
                    OFF_TIME_HI: rd_mux = 32'(snapshot[s]);
                    OFF_EVENT:   rd_mux = 32'(event_cnt[s]);
                    OFF_STATUS:  rd_mux = {29'b0, event_ovf[s],
                                           time_ovf[s], enable[s]};
                endcase
            end
        end
    end

    // Registered read data, refreshed every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule
